// File: rtl/parking_lot_counter.sv
// -----------------------------------------------------------------------------
// parking_lot_counter
//
// Occupancy tracker for the single-lane parking lot gate. It decodes the two
// gate photo-sensors into one-cycle car-entered / car-exited events and keeps
// a saturating up/down occupancy count with full/empty flags.
//
// Parameters
//   CAPACITY  maximum number of cars; count never exceeds this value
//   WIDTH     count width; 2**WIDTH must be greater than CAPACITY
//
// Ports
//   clk    system clock, all state updates on the rising edge
//   reset  asynchronous active-high reset, clears all state immediately
//   a      outer sensor, 1 = beam blocked (already synchronized to clk)
//   b      inner sensor, 1 = beam blocked (already synchronized to clk)
//   enter  registered one-cycle pulse: a complete entry sequence finished
//   exit   registered one-cycle pulse: a complete exit sequence finished
//   count  current occupancy, 0..CAPACITY
//   full   count == CAPACITY
//   empty  count == 0
// -----------------------------------------------------------------------------
module parking_lot_counter #(
  parameter int CAPACITY = 25,
  parameter int WIDTH    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             enter,
  output logic             exit,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty
);

  // A car entering blocks a, then both, then b, then clears (10,11,01,00);
  // an exiting car produces the mirror order (01,11,10,00).
  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3
  } state_t;

  localparam logic [WIDTH-1:0] CAP   = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] PLUS1 = WIDTH'(1);
  // Adding all-ones is a two's complement decrement by one.
  localparam logic [WIDTH-1:0] MINUS1 = '1;

  state_t     state;
  state_t     state_next;
  logic       enter_ev;
  logic       exit_ev;
  logic [1:0] ab;

  assign ab = {a, b};

  // NOTE: every signal written here gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    enter_ev   = 1'b0;
    exit_ev    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ab == 2'b10)      state_next = EN1;
        else if (ab == 2'b01) state_next = EX1;
        else                  state_next = IDLE;
      end
      EN1: begin
        if (ab == 2'b10)      state_next = EN1;
        else if (ab == 2'b11) state_next = EN2;
        else                  state_next = IDLE;
      end
      EN2: begin
        if (ab == 2'b11)      state_next = EN2;
        else if (ab == 2'b01) state_next = EN3;
        else if (ab == 2'b10) state_next = EN1;
        else                  state_next = IDLE;
      end
      EN3: begin
        if (ab == 2'b01)      state_next = EN3;
        else if (ab == 2'b11) state_next = EN2;
        else begin
          // 00 completes the entry; 10 is an impossible jump and aborts.
          state_next = IDLE;
          enter_ev   = (ab == 2'b00);
        end
      end
      EX1: begin
        if (ab == 2'b01)      state_next = EX1;
        else if (ab == 2'b11) state_next = EX2;
        else                  state_next = IDLE;
      end
      EX2: begin
        if (ab == 2'b11)      state_next = EX2;
        else if (ab == 2'b10) state_next = EX3;
        else if (ab == 2'b01) state_next = EX1;
        else                  state_next = IDLE;
      end
      EX3: begin
        if (ab == 2'b10)      state_next = EX3;
        else if (ab == 2'b11) state_next = EX2;
        else begin
          state_next = IDLE;
          exit_ev    = (ab == 2'b00);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
      count <= '0;
    end else begin
      state <= state_next;
      // Events are always reported, even when the count is pinned at a limit.
      enter <= enter_ev;
      exit  <= exit_ev;
      if (enter_ev && (count != CAP)) begin
        count <= count + PLUS1;
      end else if (exit_ev && (count != '0)) begin
        count <= count + MINUS1;
      end
    end
  end

  assign full  = (count == CAP);
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_counter.sv
// -----------------------------------------------------------------------------
// tb_parking_lot_counter
//
// Drives two instances from the same sensors: one with the default capacity
// (25) and one with CAPACITY = 3 so saturation is reached quickly. A sequence
// model, written in terms of "how far along the entry/exit pattern is the
// car", predicts the outputs of both instances and is compared on every
// falling edge. Directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_parking_lot_counter;

  logic clk;
  logic reset;
  logic a;
  logic b;

  logic       enter_d, exit_d, full_d, empty_d;
  logic [4:0] count_d;
  logic       enter_s, exit_s, full_s, empty_s;
  logic [1:0] count_s;

  int vectors;
  int miscompares;

  parking_lot_counter #(.CAPACITY(25), .WIDTH(5)) dut_default (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .enter (enter_d),
    .exit  (exit_d),
    .count (count_d),
    .full  (full_d),
    .empty (empty_d)
  );

  parking_lot_counter #(.CAPACITY(3), .WIDTH(2)) dut_small (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .enter (enter_s),
    .exit  (exit_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a car is described by its direction and how many steps of its
  // pattern sequence have been seen. Holding the last pattern stays, the next
  // pattern advances, the previous one steps back, 00 after the third step
  // completes the car, anything else abandons it.
  // ---------------------------------------------------------------------------
  int m_dir;             // +1 entering, -1 exiting
  int m_step;            // 0 = idle, 1..3 = patterns matched
  int m_cnt [2];
  int m_cap [2];
  bit m_enter;
  bit m_exit;

  initial begin
    m_cap[0] = 25;
    m_cap[1] = 3;
  end

  function automatic logic [1:0] seq_pat(input int dir, input int idx);
    logic [1:0] p;
    if (dir > 0) begin
      case (idx)
        0:       p = 2'b10;
        1:       p = 2'b11;
        default: p = 2'b01;
      endcase
    end else begin
      case (idx)
        0:       p = 2'b01;
        1:       p = 2'b11;
        default: p = 2'b10;
      endcase
    end
    return p;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [1:0] pat;
    if (reset) begin
      m_dir   = 0;
      m_step  = 0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_enter = 1'b0;
      m_exit  = 1'b0;
    end else begin
      pat     = {a, b};
      m_enter = 1'b0;
      m_exit  = 1'b0;
      if (m_step == 0) begin
        if (pat == 2'b10) begin
          m_dir = 1;  m_step = 1;
        end else if (pat == 2'b01) begin
          m_dir = -1; m_step = 1;
        end
      end else if (pat == seq_pat(m_dir, m_step - 1)) begin
        m_step = m_step;
      end else if (m_step < 3 && pat == seq_pat(m_dir, m_step)) begin
        m_step = m_step + 1;
      end else if (m_step >= 2 && pat == seq_pat(m_dir, m_step - 2)) begin
        m_step = m_step - 1;
      end else begin
        if (pat == 2'b00 && m_step == 3) begin
          for (int i = 0; i < 2; i++) begin
            if (m_dir > 0 && m_cnt[i] < m_cap[i]) m_cnt[i] = m_cnt[i] + 1;
            if (m_dir < 0 && m_cnt[i] > 0)        m_cnt[i] = m_cnt[i] - 1;
          end
          m_enter = (m_dir > 0);
          m_exit  = (m_dir < 0);
        end
        m_step = 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("enter_d", 32'(enter_d), 32'(m_enter));
    check("exit_d",  32'(exit_d),  32'(m_exit));
    check("count_d", 32'(count_d), 32'(m_cnt[0]));
    check("full_d",  32'(full_d),  32'(m_cnt[0] == m_cap[0]));
    check("empty_d", 32'(empty_d), 32'(m_cnt[0] == 0));
    check("enter_s", 32'(enter_s), 32'(m_enter));
    check("exit_s",  32'(exit_s),  32'(m_exit));
    check("count_s", 32'(count_s), 32'(m_cnt[1]));
    check("full_s",  32'(full_s),  32'(m_cnt[1] == m_cap[1]));
    check("empty_s", 32'(empty_s), 32'(m_cnt[1] == 0));
  end

  // Called at a falling edge; returns at the falling edge after the next
  // rising edge has sampled the pattern.
  task automatic apply(input logic [1:0] p);
    {a, b} = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic seq4(input logic [1:0] p0, input logic [1:0] p1,
                      input logic [1:0] p2, input logic [1:0] p3);
    apply(p0);
    apply(p1);
    apply(p2);
    apply(p3);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    a           = 1'b0;
    b           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_count", 32'(count_d), 32'd0);
    check("reset_empty", 32'(empty_d), 32'd1);
    check("reset_full",  32'(full_d),  32'd0);
    check("reset_enter", 32'(enter_d), 32'd0);
    reset = 1'b0;

    // Single entry from reset.
    seq4(2'b10, 2'b11, 2'b01, 2'b00);
    check("entry_enter", 32'(enter_d), 32'd1);
    check("entry_exit",  32'(exit_d),  32'd0);
    check("entry_count", 32'(count_d), 32'd1);
    check("entry_empty", 32'(empty_d), 32'd0);
    apply(2'b00);
    check("entry_pulse_end", 32'(enter_d), 32'd0);

    // Exit back to empty.
    seq4(2'b01, 2'b11, 2'b10, 2'b00);
    check("exit_exit",  32'(exit_d),  32'd1);
    check("exit_count", 32'(count_d), 32'd0);
    check("exit_empty", 32'(empty_d), 32'd1);

    // Car backs out half-way: no event.
    seq4(2'b10, 2'b11, 2'b10, 2'b00);
    check("backout_enter", 32'(enter_d), 32'd0);
    check("backout_count", 32'(count_d), 32'd0);

    // Illegal patterns from idle, then a legal entry.
    apply(2'b11);
    apply(2'b01);
    apply(2'b00);
    check("illegal_enter", 32'(enter_d), 32'd0);
    check("illegal_exit",  32'(exit_d),  32'd0);
    check("illegal_count", 32'(count_d), 32'd0);
    seq4(2'b10, 2'b11, 2'b01, 2'b00);
    check("after_illegal_count", 32'(count_d), 32'd1);

    // Back-to-back entries with no idle gap; the small instance saturates.
    for (int i = 0; i < 6; i++) begin
      seq4(2'b10, 2'b11, 2'b01, 2'b00);
      check("b2b_enter_d", 32'(enter_d), 32'd1);
      check("b2b_enter_s", 32'(enter_s), 32'd1);
      check("b2b_count_d", 32'(count_d), 32'(2 + i));
      check("b2b_count_s", 32'(count_s), (i >= 1) ? 32'd3 : 32'd2);
      check("b2b_full_s",  32'(full_s),  (i >= 1) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a cycle with count = 7 and enter high.
    #1 reset = 1'b1;
    #1;
    check("midreset_count_d", 32'(count_d), 32'd0);
    check("midreset_count_s", 32'(count_s), 32'd0);
    check("midreset_empty",   32'(empty_d), 32'd1);
    check("midreset_full_s",  32'(full_s),  32'd0);
    check("midreset_enter",   32'(enter_d), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Exit from empty: pulse, count holds at zero.
    seq4(2'b01, 2'b11, 2'b10, 2'b00);
    check("exit_empty_pulse", 32'(exit_s),  32'd1);
    check("exit_empty_count", 32'(count_s), 32'd0);

    // Reset mid-sequence discards the partial car.
    apply(2'b10);
    apply(2'b11);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apply(2'b01);
    apply(2'b00);
    check("discard_enter", 32'(enter_d), 32'd0);
    check("discard_exit",  32'(exit_d),  32'd0);
    check("discard_count", 32'(count_d), 32'd0);
    apply(2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_lot_counter.md
# parking_lot_counter

Occupancy tracker for the single-lane parking lot gate. Decodes the two gate photo-sensors into one-cycle car-entered and car-exited events, and keeps a saturating up/down occupancy count. Provides full/empty flags for the display and gate-light logic. Sits between the sensor synchronizers and the HEX/LED display drivers.

## Interface
- CAPACITY, default 25: maximum number of cars; count never exceeds this value.
- WIDTH, default 5: count width; must satisfy 2^WIDTH > CAPACITY.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- a  input  1  outer sensor, 1 = beam blocked; already synchronized to clk upstream.
- b  input  1  inner sensor, 1 = beam blocked; already synchronized to clk upstream.
- enter  output  1  registered one-cycle pulse: a complete entry sequence finished.
- exit  output  1  registered one-cycle pulse: a complete exit sequence finished.
- count  output  WIDTH  current occupancy, 0..CAPACITY.
- full  output  1  count == CAPACITY (decoded from count register).
- empty  output  1  count == 0 (decoded from count register).

## Operation
- Sensor pattern is {a,b}, sampled each rising edge.
- FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
- Entry path: IDLE -10-> EN1 -11-> EN2 -01-> EN3 -00-> IDLE with entry event.
- Exit path: IDLE -01-> EX1 -11-> EX2 -10-> EX3 -00-> IDLE with exit event.
- Holding the current state's pattern: stay in that state.
- Reversal steps back one state, no event:
  - EN2 on 10 -> EN1; EN3 on 11 -> EN2.
  - EX2 on 01 -> EX1; EX3 on 11 -> EX2.
  - EN1 on 00 -> IDLE; EX1 on 00 -> IDLE.
- Any other pattern from any state -> IDLE, no event:
  - IDLE on 11; EN1 on 01; EX1 on 10; EN2 or EX2 on 00.
  - EN3 on 10; EX3 on 01.
- Entry event:
  - If count < CAPACITY: count <= count + 1 and enter <= 1.
  - If count == CAPACITY: count holds and enter <= 1 (car is still reported; count saturates).
- Exit event:
  - If count > 0: count <= count − 1 and exit <= 1.
  - If count == 0: count holds and exit <= 1.
- Arithmetic is WIDTH-bit unsigned, ripple add of +1 or −1 (two's complement all-ones). Saturation checks prevent wrap-around at both ends.
- enter and exit are never high in the same cycle; each is high for exactly one cycle per event.

## Timing
- reset asserted: asynchronously, state = IDLE, count = 0, enter = 0, exit = 0, full = 0, empty = 1. Holds while reset is high.
- Reset mid-sequence: the partial sequence is discarded. After release, the FSM starts in IDLE; a car already between the beams is not counted unless it completes a full sequence from 00.
- Event latency: enter/exit and the new count appear together, on the same rising edge that samples 00 in EN3/EX3. full/empty follow in the same cycle, combinationally from count.
- Minimum complete sequence: 4 sampled edges (3 transitions plus the final 00). Back-to-back cars need no idle gap: the next sequence's 10 or 01 may be sampled on the edge right after the event edge.
- No input glitch filtering; sensor debounce is upstream.

## Test plan
- Reset: assert reset mid-cycle with count = 7 -> count = 0, empty = 1, enter = exit = 0 immediately, before the next clk edge.
- Entry: {a,b} = 10, 11, 01, 00 on consecutive edges from reset -> enter high one cycle on the 00 edge, count = 1, empty = 0, exit stays 0.
- Exit and aborts:
  - After the entry above, apply 01, 11, 10, 00 -> exit pulse, count = 0, empty = 1.
  - 10, 11, 10, 00 (car backs out) -> no pulse, count unchanged.
- Saturation with CAPACITY = 3:
  - Four complete entries -> count 1, 2, 3, 3; full = 1 after the third; enter pulses all four times.
  - From empty, one exit -> count stays 0, exit pulses.
- Illegal patterns: from IDLE apply 11, then 01, 00 -> no events, count unchanged, FSM ends in IDLE. A following legal entry then counts normally.
- Back-to-back: two entry sequences with no idle cycle between them -> two enter pulses four edges apart, count += 2.
